// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the MIPS fetch (I) and
// memory (D) stages. One transaction is outstanding at a time. D has priority,
// but a starvation counter hands the next arbitration to I after MAX_WAIT
// cycles of I losing.
module mips_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  // pipeline freeze
  output logic              stall_i,
  output logic              stall_d,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  state_t           state;
  logic             owner_d;     // 1: current transaction belongs to the D port
  logic [CNT_W-1:0] starve_cnt;
  logic             pick_d;
  logic             i_losing;

  // D wins unless I is waiting and has already lost MAX_WAIT cycles.
  assign pick_d = d_req && (!i_req || (starve_cnt < CNT_MAX));

  // I loses a cycle when D wins in IDLE or while D owns the memory.
  assign i_losing = i_req && ((state == IDLE) ? pick_d : owner_d);

  // A port stalls while its request is pending and not yet acknowledged.
  assign stall_i = i_req & ~i_ack;
  assign stall_d = d_req & ~d_ack;

  // Transaction FSM: owner selection, memory handshake, ack pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      // NOTE: the rdata holding registers are ordinary flops, not a memory
      // array, so they are reset along with everything else and read 0 after reset.
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      // NOTE: acks default low every cycle, so a single set below yields a
      // one-cycle pulse without any explicit clear.
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_req || i_req) begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge state and register order does not matter.
            owner_d <= pick_d;
            mem_req <= 1'b1;
            if (pick_d) begin
              mem_we    <= d_we;
              mem_be    <= d_we ? d_be : 4'hF;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= 4'hF;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              // only the D port can issue stores
              d_ack <= 1'b1;
              state <= ACK;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (owner_d) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;  // request is not re-sampled during the ack cycle
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts I losses, saturates, clears on an I ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (i_ack) begin
      starve_cnt <= '0;
    end else if (i_losing && (starve_cnt < CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter: a memory model with programmable grant delay
// and stray rvalid, request drivers, and scoreboards for acks and memory traffic.
module tb_mips_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          stall_i, stall_d;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .stall_i(stall_i), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc++;

  // memory model controls and statistics
  int          gnt_dly = 0;
  bit          stray_rv = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = '0;
  int          gnt_count = 0;
  int          req_rises = 0;

  // scoreboards
  req_t        mem_q[$];
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  req_t        d_cmd[$];
  logic [31:0] i_cmd[$];
  bit          auto_mem = 1'b1;
  bit          hold_extra = 1'b0;
  logic [31:0] d_last = '0;
  int          d_lat = 0;
  int          i_lat = 0;

  function automatic logic [31:0] rd_value(input logic [31:0] a);
    return force_en ? force_val : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  // Memory model: grants after gnt_dly waiting cycles, returns read data the
  // cycle after the grant, checks payload at grant time and while held.
  logic        acc, acc_we, prev_req = 1'b0, hold_we;
  logic [3:0]  acc_be, hold_be;
  logic [31:0] acc_addr, acc_wdata, hold_addr, hold_wdata;
  int          wait_n = 0;
  req_t        exp_m;
  always @(posedge clock) begin
    acc       = mem_gnt && mem_req;
    acc_we    = mem_we;
    acc_be    = mem_be;
    acc_addr  = mem_addr;
    acc_wdata = mem_wdata;
    if (mem_req && prev_req) begin
      check("mem_addr_stable", mem_addr, hold_addr);
      check("mem_we_stable", mem_we, hold_we);
      check("mem_be_stable", mem_be, hold_be);
      check("mem_wdata_stable", mem_wdata, hold_wdata);
    end
    if (mem_req && !prev_req) begin
      req_rises++;
      hold_addr  = mem_addr;
      hold_we    = mem_we;
      hold_be    = mem_be;
      hold_wdata = mem_wdata;
    end
    prev_req = mem_req;
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!reset_n) begin
      wait_n = 0;
    end else if (acc) begin
      gnt_count++;
      if (mem_q.size() == 0) begin
        check("mem_unexpected_txn", 1, 0);
      end else begin
        exp_m = mem_q.pop_front();
        check("mem_we", acc_we, exp_m.we);
        check("mem_be", acc_be, exp_m.be);
        check("mem_addr", acc_addr, exp_m.addr);
        if (exp_m.we) check("mem_wdata", acc_wdata, exp_m.wdata);
      end
      if (!acc_we) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_value(acc_addr);
      end
      wait_n = 0;
    end else if (mem_req) begin
      if (stray_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
      end
      if (wait_n >= gnt_dly) mem_gnt = 1'b1;
      wait_n++;
    end else begin
      wait_n = 0;
    end
  end

  // Ack scoreboard and stall checks, sampled on the falling edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (i_ack) begin
        if (i_q.size() == 0) check("i_ack_spurious", 1, 0);
        else check("i_rdata", i_rdata, i_q.pop_front());
      end
      if (d_ack) begin
        if (d_q.size() == 0) check("d_ack_spurious", 1, 0);
        else check("d_rdata", d_rdata, d_q.pop_front());
      end
      check("stall_i", stall_i, i_req & ~i_ack);
      check("stall_d", stall_d, d_req & ~d_ack);
    end
  end

  // D requester: works through d_cmd holding d_req high between commands.
  task automatic d_driver();
    req_t r;
    int   t0;
    bit   got;
    while (d_cmd.size() != 0) begin
      r = d_cmd.pop_front();
      d_req = 1'b1; d_we = r.we; d_be = r.be; d_addr = r.addr; d_wdata = r.wdata;
      if (!r.we) d_last = rd_value(r.addr);
      d_q.push_back(d_last);
      if (auto_mem) mem_q.push_back('{r.we, r.we ? r.be : 4'hF, r.addr, r.wdata});
      t0  = cyc;
      got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
        @(posedge clock); #1;
        got = d_ack;
      end
      if (!got) check("d_ack_timeout", 0, 1);
      d_lat = cyc - t0;
    end
    if (hold_extra) begin
      @(posedge clock); #1;
    end
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
  endtask

  // I requester: works through i_cmd holding i_req high between fetches.
  task automatic i_driver();
    logic [31:0] a;
    int          t0;
    bit          got;
    while (i_cmd.size() != 0) begin
      a = i_cmd.pop_front();
      i_req  = 1'b1;
      i_addr = a;
      i_q.push_back(rd_value(a));
      if (auto_mem) mem_q.push_back('{1'b0, 4'hF, a, 32'h0});
      t0  = cyc;
      got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
        @(posedge clock); #1;
        got = i_ack;
      end
      if (!got) check("i_ack_timeout", 0, 1);
      i_lat = cyc - t0;
    end
    i_req  = 1'b0;
    i_addr = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_req"}, mem_req, 0);
    check({pfx, "_mem_we"}, mem_we, 0);
    check({pfx, "_mem_be"}, mem_be, 0);
    check({pfx, "_mem_addr"}, mem_addr, 0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
    check({pfx, "_i_ack"}, i_ack, 0);
    check({pfx, "_d_ack"}, d_ack, 0);
    check({pfx, "_i_rdata"}, i_rdata, 0);
    check({pfx, "_d_rdata"}, d_rdata, 0);
    check({pfx, "_stall_i"}, stall_i, 0);
    check({pfx, "_stall_d"}, stall_d, 0);
  endtask

  initial begin
    int g0, r0;
    int t0;
    bit got;

    // power-up reset
    #12;
    check_all_zero("por");
    #10 reset_n = 1'b1;
    idle(2);

    // single I load, immediate grant, DEADBEEF
    force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    i_cmd.push_back(32'h0000_0040);
    i_driver();
    check("t2_i_latency", i_lat, 3);
    check("t2_i_rdata", i_rdata, 32'hDEAD_BEEF);
    @(negedge clock);
    check("t2_stall_i_after", stall_i, 0);
    force_en = 1'b0;
    idle(1);

    // reset asserted while a fetch is in ISSUE
    i_req = 1'b1; i_addr = 32'h0000_0080;
    @(posedge clock); #2;
    check("t1_mem_req_before", mem_req, 1);
    reset_n = 1'b0;
    i_req   = 1'b0;
    #1;
    check_all_zero("t1");
    d_last = '0;
    idle(2);
    #2 reset_n = 1'b1;
    idle(5);
    check("t1_mem_req_after", mem_req, 0);
    check("t1_i_rdata_after", i_rdata, 0);

    // D store with I idle
    g0 = gnt_count;
    d_cmd.push_back('{1'b1, 4'b0011, 32'h0000_0100, 32'h1234_5678});
    d_driver();
    check("t3_d_latency", d_lat, 2);
    idle(3);
    check("t3_gnt_count", gnt_count - g0, 1);
    check("t3_d_rdata_kept", d_rdata, 0);

    // D and I held together: D,D,I repeating with MAX_WAIT=4
    auto_mem = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        d_cmd.push_back('{1'b1, 4'hF, 32'h0000_0200 + 32'((2*k + j) * 4), 32'hA000_0000 + 32'(2*k + j)});
        mem_q.push_back('{1'b1, 4'hF, 32'h0000_0200 + 32'((2*k + j) * 4), 32'hA000_0000 + 32'(2*k + j)});
      end
      i_cmd.push_back(32'h0000_1000 + 32'(k * 4));
      mem_q.push_back('{1'b0, 4'hF, 32'h0000_1000 + 32'(k * 4), 32'h0});
    end
    fork
      d_driver();
      i_driver();
    join
    idle(3);
    check("t4_mem_q_drained", mem_q.size(), 0);
    check("t4_i_q_drained", i_q.size(), 0);
    check("t4_d_q_drained", d_q.size(), 0);
    auto_mem = 1'b1;

    // slow grant with stray rvalid during ISSUE
    gnt_dly = 5; stray_rv = 1'b1;
    d_cmd.push_back('{1'b0, 4'h0, 32'h0000_0300, 32'h0});
    d_driver();
    check("t5_load_latency", d_lat, 8);
    idle(1);
    d_cmd.push_back('{1'b1, 4'b1100, 32'h0000_0304, 32'hCAFE_F00D});
    d_driver();
    check("t5_store_latency", d_lat, 7);
    idle(1);
    i_cmd.push_back(32'h0000_0308);
    i_driver();
    check("t5_i_latency", i_lat, 8);
    gnt_dly = 0; stray_rv = 1'b0;
    idle(3);

    // request held through the ack cycle, then dropped
    g0 = gnt_count; r0 = req_rises;
    hold_extra = 1'b1;
    d_cmd.push_back('{1'b0, 4'h0, 32'h0000_0400, 32'h0});
    d_driver();
    hold_extra = 1'b0;
    idle(6);
    check("t6_gnt_count", gnt_count - g0, 1);
    check("t6_req_rises", req_rises - r0, 1);

    // request dropped mid-transaction still completes with an ack
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
    d_last = rd_value(32'h0000_0500);
    d_q.push_back(d_last);
    mem_q.push_back('{1'b0, 4'hF, 32'h0000_0500, 32'h0});
    @(posedge clock); #1;
    @(posedge clock); #1;
    d_req = 1'b0; d_addr = '0;
    got = 1'b0;
    t0  = 0;
    while (!got && t0 < 20) begin
      @(posedge clock); #1;
      got = (d_q.size() == 0) && !d_ack;
      t0++;
    end
    check("t7_ack_after_drop", got, 1);
    check("t7_d_rdata", d_rdata, rd_value(32'h0000_0500));
    idle(3);
    check("final_mem_q_drained", mem_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
